// File: rtl/ntt_sequencer_pkg.sv
// ntt_sequencer_pkg
//   Shared constants and types for the Kyber NTT sequencer slice:
//   ring/field constants, butterfly_core mode codes, the sequencer FSM
//   state encoding and the write delay-line stage record.
package ntt_sequencer_pkg;

    localparam int KYBER_N = 256;
    localparam int KYBER_Q = 3329;
    // Montgomery-domain 1/128 used by the INTT scaling pass
    localparam int F_SCALE = 1441;

    // butterfly_core mode codes
    localparam logic [1:0] BU_NTT    = 2'd0;
    localparam logic [1:0] BU_INVNTT = 2'd1;
    localparam logic [1:0] BU_MULT   = 2'd2;
    localparam logic [1:0] BU_ADDSUB = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_SCALE,
        ST_SDRAIN,
        ST_DONE
    } state_t;

    // One slot of the read-to-write delay line
    typedef struct packed {
        logic       valid;
        logic [7:0] addr_a;
        logic [7:0] addr_b;
    } wr_stage_t;

endpackage

// File: rtl/ntt_sequencer_if.sv
// ntt_sequencer_if
//   Bundles the sequencer's control (start/op/busy/done) and datapath
//   control (RAM read/write strobes and addresses, zeta index, coef select,
//   butterfly mode) signals.
//   master: the sequencer side (drives everything except start/op)
//   slave : the environment side (drives start/op, observes the rest)
interface ntt_sequencer_if;
    logic       start;
    logic       op;
    logic       busy;
    logic       done;
    logic       rd_en;
    logic [7:0] rd_addr_a;
    logic [7:0] rd_addr_b;
    logic [6:0] zeta_idx;
    logic       coef_sel;
    logic [1:0] bu_mode;
    logic       wr_en;
    logic [7:0] wr_addr_a;
    logic [7:0] wr_addr_b;

    modport master (
        input  start, op,
        output busy, done, rd_en, rd_addr_a, rd_addr_b, zeta_idx, coef_sel,
               bu_mode, wr_en, wr_addr_a, wr_addr_b
    );

    modport slave (
        output start, op,
        input  busy, done, rd_en, rd_addr_a, rd_addr_b, zeta_idx, coef_sel,
               bu_mode, wr_en, wr_addr_a, wr_addr_b
    );
endinterface

// File: rtl/ntt_sequencer_addr_gen.sv
// ntt_sequencer_addr_gen
//   Combinational butterfly address / zeta-index generator.
//   Ports:
//     op       in  0: forward NTT, 1: inverse NTT
//     layer    in  layer number 0..6
//     bfly     in  butterfly number within the layer 0..127
//     scale    in  1 during the INTT scaling pass (pairs 2b, 2b+1)
//     addr_a   out first coefficient address
//     addr_b   out second coefficient address (addr_a + len)
//     zeta_idx out zeta ROM index (0 during scaling)
module ntt_sequencer_addr_gen (
    input  logic       op,
    input  logic [2:0] layer,
    input  logic [6:0] bfly,
    input  logic       scale,
    output logic [7:0] addr_a,
    output logic [7:0] addr_b,
    output logic [6:0] zeta_idx
);
    logic [7:0] len;
    logic [7:0] grp;
    logic [7:0] base;
    logic [7:0] offs;

    // len is always a power of two, so "b mod len" is a mask and
    // grp*2*len never exceeds 254: 8-bit arithmetic is exact.
    always_comb begin
        if (op) begin
            len = 8'd2 << layer;
            grp = {1'b0, bfly} >> (layer + 3'd1);
        end else begin
            len = 8'd128 >> layer;
            grp = {1'b0, bfly} >> (3'd7 - layer);
        end
        offs = {1'b0, bfly} & (len - 8'd1);
        base = (grp * len) << 1;

        if (scale) begin
            addr_a   = {bfly, 1'b0};
            addr_b   = {bfly, 1'b1};
            zeta_idx = '0;
        end else begin
            addr_a   = base + offs;
            addr_b   = base + offs + len;
            // INTT walks the zeta table backwards: (128>>l)-1 == 7'h7F>>l
            zeta_idx = op ? ((7'h7F >> layer) - grp[6:0])
                          : ((7'd1 << layer) + grp[6:0]);
        end
    end
endmodule

// File: rtl/ntt_sequencer.sv
// ntt_sequencer
//   Drives one butterfly_core plus a dual-port 256x12 coefficient RAM and
//   zeta ROM through a full Kyber NTT (op=0) or INTT with the final
//   scaling pass (op=1). One butterfly is issued per cycle; the pipeline
//   is drained at every layer boundary so the next layer never reads a
//   coefficient before its write has landed.
//   Ports:
//     clk  in  clock, rising edge
//     rst  in  asynchronous reset, active low
//     bus  ntt_sequencer_if.master: start/op in; busy/done, RAM read and
//          write strobes/addresses, zeta_idx, coef_sel, bu_mode out
module ntt_sequencer
    import ntt_sequencer_pkg::*;
#(
    parameter int BU_LAT  = 3,
    parameter int RAM_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    ntt_sequencer_if.master        bus
);
    localparam int PIPE    = RAM_LAT + BU_LAT;
    localparam int DRAIN_W = $clog2(PIPE + 1);

    state_t               state_reg, state_next;
    logic                 op_reg, op_next;
    logic [2:0]           layer_reg, layer_next;
    logic [6:0]           bfly_reg, bfly_next;
    logic [DRAIN_W-1:0]   drain_reg, drain_next;

    logic                 in_scale;
    logic                 rd_en;
    logic [7:0]           gen_a, gen_b;
    logic [6:0]           gen_z;
    logic [1:0]           issue_mode;
    wr_stage_t            issue_stage;

    wr_stage_t            wr_dl_reg   [PIPE];
    logic [1:0]           mode_dl_reg [RAM_LAT];

    ntt_sequencer_addr_gen u_addr_gen (
        .op       (op_reg),
        .layer    (layer_reg),
        .bfly     (bfly_reg),
        .scale    (in_scale),
        .addr_a   (gen_a),
        .addr_b   (gen_b),
        .zeta_idx (gen_z)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            op_reg    <= 1'b0;
            layer_reg <= '0;
            bfly_reg  <= '0;
            drain_reg <= '0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            layer_reg <= layer_next;
            bfly_reg  <= bfly_next;
            drain_reg <= drain_next;
        end
    end

    // bfly wraps 127 -> 0 on its own, so every RUN/SCALE pass starts at 0
    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        layer_next = layer_reg;
        bfly_next  = bfly_reg;
        drain_next = drain_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next = ST_RUN;
                    op_next    = bus.op;
                    layer_next = '0;
                    bfly_next  = '0;
                end
            end
            ST_RUN, ST_SCALE: begin
                bfly_next = bfly_reg + 7'd1;
                if (bfly_reg == 7'd127) begin
                    state_next = (state_reg == ST_RUN) ? ST_DRAIN : ST_SDRAIN;
                    drain_next = '0;
                end
            end
            ST_DRAIN: begin
                drain_next = drain_reg + 1'b1;
                if (drain_reg == DRAIN_W'(PIPE - 1)) begin
                    if (layer_reg == 3'd6) begin
                        state_next = op_reg ? ST_SCALE : ST_DONE;
                    end else begin
                        state_next = ST_RUN;
                        layer_next = layer_reg + 3'd1;
                    end
                end
            end
            ST_SDRAIN: begin
                drain_next = drain_reg + 1'b1;
                if (drain_reg == DRAIN_W'(PIPE - 1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign in_scale   = (state_reg == ST_SCALE);
    assign rd_en      = (state_reg == ST_RUN) || in_scale;
    assign issue_mode = !rd_en   ? BU_NTT :
                        in_scale ? BU_MULT :
                        op_reg   ? BU_INVNTT : BU_NTT;
    // Addresses are zeroed when idle so inactive slots carry no stale data
    assign issue_stage = '{valid: rd_en,
                           addr_a: rd_en ? gen_a : 8'd0,
                           addr_b: rd_en ? gen_b : 8'd0};

    // Read-to-write delay line: stage PIPE-1 drives the RAM write port
    for (genvar gi = 0; gi < PIPE; gi++) begin : g_wr_dl
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                wr_dl_reg[gi] <= '0;
            end else if (gi == 0) begin
                wr_dl_reg[gi] <= issue_stage;
            end else begin
                wr_dl_reg[gi] <= wr_dl_reg[(gi == 0) ? 0 : gi - 1];
            end
        end
    end

    // Mode follows the read data out of the RAM into the butterfly input
    for (genvar gi = 0; gi < RAM_LAT; gi++) begin : g_mode_dl
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                mode_dl_reg[gi] <= BU_NTT;
            end else if (gi == 0) begin
                mode_dl_reg[gi] <= issue_mode;
            end else begin
                mode_dl_reg[gi] <= mode_dl_reg[(gi == 0) ? 0 : gi - 1];
            end
        end
    end

    assign bus.busy      = (state_reg == ST_RUN)   || (state_reg == ST_DRAIN) ||
                           (state_reg == ST_SCALE) || (state_reg == ST_SDRAIN);
    assign bus.done      = (state_reg == ST_DONE);
    assign bus.rd_en     = rd_en;
    assign bus.rd_addr_a = issue_stage.addr_a;
    assign bus.rd_addr_b = issue_stage.addr_b;
    assign bus.zeta_idx  = (state_reg == ST_RUN) ? gen_z : 7'd0;
    assign bus.coef_sel  = in_scale;
    assign bus.bu_mode   = mode_dl_reg[RAM_LAT-1];
    assign bus.wr_en     = wr_dl_reg[PIPE-1].valid;
    assign bus.wr_addr_a = wr_dl_reg[PIPE-1].addr_a;
    assign bus.wr_addr_b = wr_dl_reg[PIPE-1].addr_b;

endmodule

// File: tb/tb_ntt_sequencer.sv
// tb_ntt_sequencer
//   Checks the issue sequence of ntt_sequencer against the Kyber reference
//   loop nest, the read-to-write delay through a write scoreboard, the
//   start/done timing, start-while-busy rejection and asynchronous abort.
module tb_ntt_sequencer;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [6:0] z;
        logic       cs;
        logic [1:0] mode;
        bit         chk_z;
        int         off;
    } iss_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         due;
    } wr_t;

    typedef struct {
        bit         op;
        int         idx;
        logic [7:0] a;
        logic [7:0] b;
        logic [6:0] z;
        logic       cs;
        logic [1:0] mode;
        bit         chk_z;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   start_cyc = 0;
    int   issue_idx = 0;

    iss_t exp_q[$];
    wr_t  wr_q[$];
    bit   mode_pend = 0;
    logic [1:0] mode_exp;
    int   mode_idx;

    logic [7:0] log_a [1024];
    logic [7:0] log_b [1024];
    logic [6:0] log_z [1024];
    logic       log_cs [1024];
    logic [1:0] log_mode [1024];

    vec_t vecs [10];

    ntt_sequencer_if bus ();

    ntt_sequencer #(.BU_LAT(3), .RAM_LAT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    endtask

    function automatic logic [63:0] all_outs();
        return {18'd0, bus.rd_en, bus.rd_addr_a, bus.rd_addr_b, bus.zeta_idx,
                bus.coef_sel, bus.bu_mode, bus.wr_en, bus.wr_addr_a,
                bus.wr_addr_b, bus.busy, bus.done};
    endfunction

    // Expected issue order from the reference Kyber loop nests
    task automatic load_expected(input bit op_i);
        int   k;
        int   idx;
        iss_t e;
        exp_q.delete();
        idx = 0;
        if (!op_i) begin
            k = 1;
            for (int len = 128; len >= 2; len = len / 2) begin
                for (int st = 0; st < 256; st = st + 2 * len) begin
                    for (int j = st; j < st + len; j++) begin
                        e.a = 8'(j); e.b = 8'(j + len); e.z = 7'(k); e.cs = 1'b0;
                        e.mode = 2'd0; e.chk_z = 1; e.off = (idx / 128) * 132 + idx % 128;
                        exp_q.push_back(e);
                        idx++;
                    end
                    k++;
                end
            end
        end else begin
            k = 127;
            for (int len = 2; len <= 128; len = len * 2) begin
                for (int st = 0; st < 256; st = st + 2 * len) begin
                    for (int j = st; j < st + len; j++) begin
                        e.a = 8'(j); e.b = 8'(j + len); e.z = 7'(k); e.cs = 1'b0;
                        e.mode = 2'd1; e.chk_z = 1; e.off = (idx / 128) * 132 + idx % 128;
                        exp_q.push_back(e);
                        idx++;
                    end
                    k--;
                end
            end
            for (int j = 0; j < 128; j++) begin
                e.a = 8'(2 * j); e.b = 8'(2 * j + 1); e.z = 7'd0; e.cs = 1'b1;
                e.mode = 2'd2; e.chk_z = 0; e.off = (idx / 128) * 132 + idx % 128;
                exp_q.push_back(e);
                idx++;
            end
        end
    endtask

    // Monitor: issue checks, bu_mode alignment, write scoreboard
    always @(negedge clk) begin
        iss_t e;
        wr_t  w;
        if (rst) begin
            if (mode_pend) begin
                check("bu_mode", 64'(bus.bu_mode), 64'(mode_exp));
                if (mode_idx < 1024) log_mode[mode_idx] = bus.bu_mode;
                mode_pend = 0;
            end
            if (bus.wr_en) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_wr", 64'(bus.wr_en), 64'd0);
                end else begin
                    w = wr_q.pop_front();
                    check("wr_addr_and_delay", {bus.wr_addr_a, bus.wr_addr_b, 32'(cyc)},
                          {w.a, w.b, 32'(w.due)});
                end
            end else if (wr_q.size() > 0 && wr_q[0].due <= cyc) begin
                w = wr_q.pop_front();
                check("missing_wr", 64'(bus.wr_en), 64'd1);
            end
            if (bus.rd_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rd", 64'(bus.rd_en), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("issue", {bus.rd_addr_a, bus.rd_addr_b,
                                    (e.chk_z ? bus.zeta_idx : 7'd0), bus.coef_sel},
                          {e.a, e.b, (e.chk_z ? e.z : 7'd0), e.cs});
                    check("issue_cycle", 64'(cyc - start_cyc), 64'(e.off));
                    mode_pend = 1;
                    mode_exp  = e.mode;
                end
                if (issue_idx < 1024) begin
                    log_a[issue_idx]  = bus.rd_addr_a;
                    log_b[issue_idx]  = bus.rd_addr_b;
                    log_z[issue_idx]  = bus.zeta_idx;
                    log_cs[issue_idx] = bus.coef_sel;
                end
                mode_idx = issue_idx;
                issue_idx++;
                w.a = bus.rd_addr_a; w.b = bus.rd_addr_b; w.due = cyc + 4;
                wr_q.push_back(w);
            end
        end
    end

    // Runs one operation. inject_at: offset to pulse start (ignored by DUT);
    // abort_at: offset to assert reset. Returns at the negedge of the DONE
    // cycle (or right after the abort).
    task automatic run_op(input bit op_i, input int inject_at, input int abort_at);
        bit seen_done;
        int exp_done;
        load_expected(op_i);
        issue_idx = 0;
        exp_done  = op_i ? 1056 : 924;
        bus.start = 1'b1;
        bus.op    = op_i;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        bus.start = 1'b0;
        check("busy_after_start", 64'(bus.busy), 64'd1);
        seen_done = 0;
        for (int off = 0; off < 2000 && !seen_done; off++) begin
            @(negedge clk);
            if (off == abort_at) begin
                #2;
                rst = 1'b0;
                #1;
                check("outputs_zero_on_abort", all_outs(), 64'd0);
                exp_q.delete();
                wr_q.delete();
                mode_pend = 0;
                $display("run op=%0d aborted at offset %0d", op_i, off);
                return;
            end
            if (off == inject_at) begin
                bus.start = 1'b1;
                bus.op    = ~op_i;
            end else if (off == inject_at + 1) begin
                bus.start = 1'b0;
                bus.op    = op_i;
            end
            if (bus.done) begin
                seen_done = 1;
                check("done_cycle", 64'(cyc - start_cyc), 64'(exp_done));
                check("busy_low_at_done", 64'(bus.busy), 64'd0);
            end
        end
        check("done_seen", 64'(seen_done), 64'd1);
        check("all_issued_and_written", 64'(exp_q.size() + wr_q.size()), 64'd0);
        $display("run op=%0d done at offset %0d", op_i, cyc - start_cyc);
    endtask

    task automatic apply_table(input bit op_i);
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].op == op_i) begin
                check($sformatf("vec%0d", i),
                      {log_a[vecs[i].idx], log_b[vecs[i].idx],
                       (vecs[i].chk_z ? log_z[vecs[i].idx] : 7'd0),
                       log_cs[vecs[i].idx], log_mode[vecs[i].idx]},
                      {vecs[i].a, vecs[i].b, (vecs[i].chk_z ? vecs[i].z : 7'd0),
                       vecs[i].cs, vecs[i].mode});
            end
        end
    endtask

    initial begin
        int n_wr;
        int n_rd;
        // {op, issue index (layer*128+b), addr_a, addr_b, zeta, coef_sel, bu_mode, zeta checked}
        vecs[0] = '{0, 0,         8'd0,   8'd128, 7'd1,   1'b0, 2'd0, 1};
        vecs[1] = '{0, 1,         8'd1,   8'd129, 7'd1,   1'b0, 2'd0, 1};
        vecs[2] = '{0, 64,        8'd64,  8'd192, 7'd1,   1'b0, 2'd0, 1};
        vecs[3] = '{0, 128 + 64,  8'd128, 8'd192, 7'd3,   1'b0, 2'd0, 1};
        vecs[4] = '{0, 768 + 127, 8'd253, 8'd255, 7'd127, 1'b0, 2'd0, 1};
        vecs[5] = '{1, 0,         8'd0,   8'd2,   7'd127, 1'b0, 2'd1, 1};
        vecs[6] = '{1, 1,         8'd1,   8'd3,   7'd127, 1'b0, 2'd1, 1};
        vecs[7] = '{1, 2,         8'd4,   8'd6,   7'd126, 1'b0, 2'd1, 1};
        vecs[8] = '{1, 768,       8'd0,   8'd128, 7'd1,   1'b0, 2'd1, 1};
        vecs[9] = '{1, 896 + 5,   8'd10,  8'd11,  7'd0,   1'b1, 2'd2, 0};

        bus.start = 1'b0;
        bus.op    = 1'b0;
        rst       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", all_outs(), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // NTT with a start pulse mid-run
        run_op(1'b0, 300, -1);
        apply_table(1'b0);

        // start held through DONE (ignored) into IDLE (accepted)
        bus.start = 1'b1;
        bus.op    = 1'b1;
        @(posedge clk);
        #1;
        check("start_in_done_ignored", {62'd0, bus.busy, bus.done}, 64'd0);
        run_op(1'b1, -1, -1);
        apply_table(1'b1);
        @(posedge clk);
        #1;
        check("idle_after_intt", {62'd0, bus.busy, bus.done}, 64'd0);

        // INTT aborted by reset
        run_op(1'b1, -1, 500);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst  = 1'b1;
        n_wr = 0;
        n_rd = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_wr += int'(bus.wr_en);
            n_rd += int'(bus.rd_en);
        end
        check("no_activity_after_abort", {32'(n_wr), 32'(n_rd)}, 64'd0);
        check("idle_after_abort", {62'd0, bus.busy, bus.done}, 64'd0);

        // fresh run after the abort
        run_op(1'b0, -1, -1);
        @(posedge clk);
        #1;
        check("idle_at_end", {62'd0, bus.busy, bus.done}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
